// File: rtl/led_blink_scheduler.sv
// Shared-LED blink-code scheduler: request i plays i+1 blinks then a gap.
// Pending requests are latched and served round-robin, one code at a time.
module led_blink_scheduler #(
    parameter logic [23:0] ON_CYCLES  = 24'd1_000_000,
    parameter logic [23:0] OFF_CYCLES = 24'd1_000_000,
    parameter logic [23:0] GAP_CYCLES = 24'd4_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       enable,
    output logic       led,
    output logic       busy,
    output logic [1:0] active_id,
    output logic [3:0] done
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [23:0] timer;
    logic [23:0] timer_nx;
    logic [1:0]  blink_cnt;
    logic [1:0]  blink_cnt_nx;
    logic [1:0]  rr_ptr;
    logic [1:0]  rr_ptr_nx;
    logic [1:0]  active_id_nx;
    logic [3:0]  done_nx;
    logic [3:0]  pending;
    logic [3:0]  pending_clr;
    logic        sel_valid;
    logic [1:0]  sel_id;
    logic [1:0]  cand;

    // Search starts just above the last winner; k=4 wraps back to rr_ptr.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = rr_ptr;
        cand      = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!sel_valid && pending[cand]) begin
                sel_valid = 1'b1;
                sel_id    = cand;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        blink_cnt_nx = blink_cnt;
        rr_ptr_nx    = rr_ptr;
        active_id_nx = active_id;
        done_nx      = 4'b0000;
        pending_clr  = 4'b0000;
        unique case (state)
            IDLE: begin
                if (enable && sel_valid) begin
                    state_nx             = ON;
                    active_id_nx         = sel_id;
                    blink_cnt_nx         = sel_id;
                    rr_ptr_nx            = sel_id;
                    timer_nx             = ON_CYCLES - 24'd1;
                    pending_clr[sel_id]  = 1'b1;
                end
            end
            ON: begin
                if (timer == 24'd0) begin
                    state_nx = OFF;
                    timer_nx = OFF_CYCLES - 24'd1;
                end else begin
                    timer_nx = timer - 24'd1;
                end
            end
            OFF: begin
                if (timer == 24'd0) begin
                    if (blink_cnt == 2'd0) begin
                        state_nx = GAP;
                        timer_nx = GAP_CYCLES - 24'd1;
                    end else begin
                        state_nx     = ON;
                        blink_cnt_nx = blink_cnt - 2'd1;
                        timer_nx     = ON_CYCLES - 24'd1;
                    end
                end else begin
                    timer_nx = timer - 24'd1;
                end
            end
            GAP: begin
                if (timer == 24'd0) begin
                    state_nx           = IDLE;
                    done_nx[active_id] = 1'b1;
                end else begin
                    timer_nx = timer - 24'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= 24'd0;
            blink_cnt <= 2'd0;
            rr_ptr    <= 2'd3;
            pending   <= 4'b0000;
            led       <= 1'b0;
            busy      <= 1'b0;
            active_id <= 2'd0;
            done      <= 4'b0000;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            blink_cnt <= blink_cnt_nx;
            rr_ptr    <= rr_ptr_nx;
            pending   <= (pending & ~pending_clr) | req;
            led       <= (state_nx == ON);
            busy      <= (state_nx != IDLE);
            active_id <= active_id_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with ON=3, OFF=2, GAP=4.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_led_blink_scheduler;

    localparam int ON_C  = 3;
    localparam int OFF_C = 2;
    localparam int GAP_C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       enable = 1'b0;
    logic       led;
    logic       busy;
    logic [1:0] active_id;
    logic [3:0] done;

    int checks = 0;
    int passed = 0;

    led_blink_scheduler #(
        .ON_CYCLES (24'(ON_C)),
        .OFF_CYCLES(24'(OFF_C)),
        .GAP_CYCLES(24'(GAP_C))
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .enable   (enable),
        .led      (led),
        .busy     (busy),
        .active_id(active_id),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int code_len(int id);
        return (id + 1) * (ON_C + OFF_C) + GAP_C;
    endfunction

    function automatic logic exp_led(int id, int n);
        return (n < (id + 1) * (ON_C + OFF_C)) && ((n % (ON_C + OFF_C)) < ON_C);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({led, busy, active_id, done} !== 8'b0)
            $display("FAIL reset_hold led=%b busy=%b id=%0d done=%b exp all 0",
                     led, busy, active_id, done);
        else passed++;
        reset = 1'b0;
        tick();
        checks++;
        if ({led, busy, active_id, done} !== 8'b0)
            $display("FAIL reset_release led=%b busy=%b id=%0d done=%b exp all 0",
                     led, busy, active_id, done);
        else passed++;
    endtask

    task automatic test_single();
        enable = 1'b1;
        req    = 4'b0100;
        tick();
        req = 4'b0000;
        checks++;
        if (led !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_pre led=%b busy=%b exp 0 0", led, busy);
        else passed++;
        tick();
        for (int n = 0; n < code_len(2); n++) begin
            checks++;
            if (led !== exp_led(2, n) || busy !== 1'b1 || done !== 4'b0 || active_id !== 2'd2)
                $display("FAIL single n=%0d led=%b busy=%b done=%b id=%0d exp led=%b busy=1 done=0 id=2",
                         n, led, busy, done, active_id, exp_led(2, n));
            else passed++;
            tick();
        end
        checks++;
        if (done !== 4'b0100 || busy !== 1'b0 || led !== 1'b0 || active_id !== 2'd2)
            $display("FAIL single_done done=%b busy=%b led=%b id=%0d exp 0100 0 0 2",
                     done, busy, led, active_id);
        else passed++;
        tick();
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0)
            $display("FAIL single_after done=%b busy=%b exp 0000 0", done, busy);
        else passed++;
    endtask

    task automatic test_all();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        req    = 4'b1111;
        tick();
        req = 4'b0000;
        tick();
        for (int id = 0; id < 4; id++) begin
            for (int n = 0; n < code_len(id); n++) begin
                checks++;
                if (led !== exp_led(id, n) || busy !== 1'b1 || done !== 4'b0 || active_id !== 2'(id))
                    $display("FAIL all id=%0d n=%0d led=%b busy=%b done=%b act=%0d exp led=%b",
                             id, n, led, busy, done, active_id, exp_led(id, n));
                else passed++;
                tick();
            end
            checks++;
            if (done !== 4'(1 << id) || busy !== 1'b0)
                $display("FAIL all_done id=%0d done=%b busy=%b exp %b 0",
                         id, done, busy, 4'(1 << id));
            else passed++;
            tick();
        end
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || led !== 1'b0)
            $display("FAIL all_idle done=%b busy=%b led=%b exp 0", done, busy, led);
        else passed++;
    endtask

    task automatic test_collapse();
        int seq[3];
        seq = '{0, 3, 0};
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        for (int c = 0; c < 3; c++) begin
            for (int n = 0; n < code_len(seq[c]); n++) begin
                checks++;
                if (led !== exp_led(seq[c], n) || busy !== 1'b1 || active_id !== 2'(seq[c]))
                    $display("FAIL collapse c=%0d n=%0d led=%b busy=%b act=%0d exp led=%b act=%0d",
                             c, n, led, busy, active_id, exp_led(seq[c], n), seq[c]);
                else passed++;
                if (c == 0)
                    req = (n == 1 || n == 3) ? 4'b0001 : (n == 5) ? 4'b1000 : 4'b0000;
                tick();
            end
            req = 4'b0000;
            checks++;
            if (done !== 4'(1 << seq[c]) || busy !== 1'b0)
                $display("FAIL collapse_done c=%0d done=%b busy=%b exp %b 0",
                         c, done, busy, 4'(1 << seq[c]));
            else passed++;
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (busy !== 1'b0 || led !== 1'b0 || done !== 4'b0)
                $display("FAIL collapse_idle i=%0d busy=%b led=%b done=%b exp 0", i, busy, led, done);
            else passed++;
            tick();
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        req    = 4'b0010;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (led !== 1'b0 || busy !== 1'b0)
                $display("FAIL enable_off i=%0d led=%b busy=%b exp 0 0", i, led, busy);
            else passed++;
            tick();
        end
        enable = 1'b1;
        tick();
        for (int n = 0; n < code_len(1); n++) begin
            checks++;
            if (led !== exp_led(1, n) || busy !== 1'b1 || active_id !== 2'd1)
                $display("FAIL enable_code n=%0d led=%b busy=%b act=%0d exp led=%b act=1",
                         n, led, busy, active_id, exp_led(1, n));
            else passed++;
            tick();
        end
        checks++;
        if (done !== 4'b0010 || busy !== 1'b0)
            $display("FAIL enable_done done=%b busy=%b exp 0010 0", done, busy);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        for (int n = 0; n < 6; n++) tick();
        checks++;
        if (led !== 1'b1 || busy !== 1'b1)
            $display("FAIL rstmid_on2 led=%b busy=%b exp 1 1", led, busy);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (led !== 1'b0 || busy !== 1'b0 || done !== 4'b0 || active_id !== 2'd0)
            $display("FAIL rstmid_now led=%b busy=%b done=%b act=%0d exp 0", led, busy, done, active_id);
        else passed++;
        tick();
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (led !== 1'b0 || busy !== 1'b0 || done !== 4'b0)
                $display("FAIL rstmid_quiet i=%0d led=%b busy=%b done=%b exp 0", i, led, busy, done);
            else passed++;
            tick();
        end
        req = 4'b1001;
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if (led !== 1'b1 || active_id !== 2'd0)
            $display("FAIL rstmid_rr led=%b act=%0d exp 1 0", led, active_id);
        else passed++;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (busy !== 1'b0 || led !== 1'b0)
            $display("FAIL rstmid_drain busy=%b led=%b exp 0 0", busy, led);
        else passed++;
    endtask

    task automatic test_enable_drop();
        enable = 1'b1;
        req    = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        for (int n = 0; n < code_len(2); n++) begin
            checks++;
            if (led !== exp_led(2, n) || busy !== 1'b1 || active_id !== 2'd2)
                $display("FAIL drop n=%0d led=%b busy=%b act=%0d exp led=%b act=2",
                         n, led, busy, active_id, exp_led(2, n));
            else passed++;
            if (n == 3) enable = 1'b0;
            req = (n == 4) ? 4'b0010 : 4'b0000;
            tick();
        end
        checks++;
        if (done !== 4'b0100 || busy !== 1'b0)
            $display("FAIL drop_done done=%b busy=%b exp 0100 0", done, busy);
        else passed++;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b0 || led !== 1'b0 || done !== 4'b0)
                $display("FAIL drop_idle i=%0d busy=%b led=%b done=%b exp 0", i, busy, led, done);
            else passed++;
            tick();
        end
        enable = 1'b1;
        tick();
        checks++;
        if (led !== 1'b1 || active_id !== 2'd1)
            $display("FAIL drop_resume led=%b act=%0d exp 1 1", led, active_id);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_collapse();
        test_enable();
        test_reset_mid();
        test_enable_drop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
